// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the main-memory burst engine and the L2 cache.
package mem_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned DATA_WIDTH_MEM = 64;
  localparam int unsigned BURST_LENGTH   = 8;

  // Byte address fields: [2:0] byte in word, [5:3] word in line, [10:6] line index
  localparam int unsigned WORD_LSB   = 3;
  localparam int unsigned WORD_BITS  = 3;
  localparam int unsigned LINE_LSB   = 6;
  localparam int unsigned LINE_BITS  = 5;
  localparam int unsigned ENTRY_BITS = LINE_BITS + WORD_BITS;
  localparam int unsigned BEAT_BITS  = $clog2(BURST_LENGTH);

  typedef enum logic [1:0] {
    StIdle,
    StLatency,
    StBurstData,
    StBurstStb
  } mem_state_e;

endpackage

// File: rtl/main_mem_burst_if.sv
// L2 <-> main memory line-transfer bus; the L2 is the master, the memory block the slave.
interface main_mem_burst_if #(
  parameter int unsigned ADDR_WIDTH     = mem_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH_MEM = mem_pkg::DATA_WIDTH_MEM
) ();

  logic                      req;
  logic                      we_MEM;
  logic [ADDR_WIDTH-1:0]     addr_MEM;
  logic [DATA_WIDTH_MEM-1:0] data_in;
  logic [DATA_WIDTH_MEM-1:0] data_out;
  logic                      data_oe;
  logic                      stb;
  logic                      busy;

  modport master (
    output req, we_MEM, addr_MEM, data_in,
    input  data_out, data_oe, stb, busy
  );

  modport slave (
    input  req, we_MEM, addr_MEM, data_in,
    output data_out, data_oe, stb, busy
  );

endinterface

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, combinational read on the shared address.
module mem_array #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = mem_pkg::DATA_WIDTH_MEM,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_addr,
  input  logic [Width-1:0] i_wdata,
  output logic [Width-1:0] o_rdata
);

  // Deliberately no reset: contents survive a reset of the controller
  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/main_mem_burst.sv
// Main-memory line transfer engine: fixed access latency, then a critical-word-first
// burst where every stb edge (rise or fall) carries one 64-bit beat.
module main_mem_burst #(
  parameter int unsigned ADDR_WIDTH     = mem_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH_MEM = mem_pkg::DATA_WIDTH_MEM,
  parameter int unsigned BURST_LENGTH   = mem_pkg::BURST_LENGTH,
  parameter int unsigned ACCESS_LATENCY = 4,
  parameter int unsigned MEM_DEPTH      = 256
) (
  input logic             clk,
  input logic             rst_n,
  main_mem_burst_if.slave bus
);

  import mem_pkg::mem_state_e;
  import mem_pkg::StIdle;
  import mem_pkg::StLatency;
  import mem_pkg::StBurstData;
  import mem_pkg::StBurstStb;
  import mem_pkg::WORD_LSB;
  import mem_pkg::WORD_BITS;
  import mem_pkg::LINE_LSB;
  import mem_pkg::LINE_BITS;
  import mem_pkg::ENTRY_BITS;
  import mem_pkg::BEAT_BITS;

  localparam int unsigned LatW = $clog2(ACCESS_LATENCY + 1);

  mem_state_e                r_state;
  logic [LatW-1:0]           r_lat;
  logic [BEAT_BITS-1:0]      r_beat;
  logic [LINE_BITS-1:0]      r_line;
  logic [WORD_BITS-1:0]      r_word;
  logic                      r_read;
  logic                      r_stb;
  logic                      r_busy;
  logic                      r_oe;
  logic [DATA_WIDTH_MEM-1:0] r_data;

  logic [BEAT_BITS-1:0]      w_beat;
  logic [ENTRY_BITS-1:0]     w_entry;
  logic                      w_we;
  logic [DATA_WIDTH_MEM-1:0] w_rdata;

  // Address the entry the next register load needs: the upcoming beat while in BURST_STB
  assign w_beat  = (r_state == StBurstStb) ? r_beat + BEAT_BITS'(1) : r_beat;
  assign w_entry = {r_line, WORD_BITS'(r_word + w_beat)};
  assign w_we    = (r_state == StBurstData) && !r_read;

  mem_array #(
    .Depth (MEM_DEPTH),
    .Width (DATA_WIDTH_MEM),
    .AddrW (ENTRY_BITS)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_entry),
    .i_wdata (bus.data_in),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_lat   <= '0;
      r_beat  <= '0;
      r_line  <= '0;
      r_word  <= '0;
      r_read  <= 1'b0;
      r_stb   <= 1'b0;
      r_busy  <= 1'b0;
      r_oe    <= 1'b0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.req) begin
            r_state <= StLatency;
            r_busy  <= 1'b1;
            r_read  <= bus.we_MEM;
            r_line  <= bus.addr_MEM[LINE_LSB +: LINE_BITS];
            r_word  <= bus.addr_MEM[WORD_LSB +: WORD_BITS];
            r_lat   <= LatW'(ACCESS_LATENCY - 1);
            r_beat  <= '0;
          end
        end
        StLatency: begin
          if (r_lat == '0) begin
            r_state <= StBurstData;
            if (r_read) begin
              r_data <= w_rdata;
              r_oe   <= 1'b1;
            end
          end else begin
            r_lat <= r_lat - LatW'(1);
          end
        end
        StBurstData: begin
          r_state <= StBurstStb;
          r_stb   <= ~r_stb;
        end
        StBurstStb: begin
          if (r_beat == BEAT_BITS'(BURST_LENGTH - 1)) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_oe    <= 1'b0;
            r_beat  <= '0;
          end else begin
            r_state <= StBurstData;
            r_beat  <= r_beat + BEAT_BITS'(1);
            if (r_read) begin
              r_data <= w_rdata;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.data_out = r_data;
  assign bus.data_oe  = r_oe;
  assign bus.stb      = r_stb;
  assign bus.busy     = r_busy;

  // Only address bits [10:3] select an entry; the rest alias
  logic unused_addr;
  assign unused_addr = ^{bus.addr_MEM[ADDR_WIDTH-1:LINE_LSB+LINE_BITS],
                         bus.addr_MEM[WORD_LSB-1:0]};

endmodule

// File: tb/tb_main_mem_burst.sv
// Self-checking bench for main_mem_burst: vector table of line transfers checked against
// a shadow memory and a read-data scoreboard, plus hand-written reset-abort sequences.
module tb_main_mem_burst;

  logic clk;
  logic rst_n;

  main_mem_burst_if bus ();

  main_mem_burst dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [63:0] wbase;
    bit          inject;
    bit          b2b;
    logic [63:0] order;  // byte k = expected entry for beat k
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] shadow [256];
  logic [63:0] sb_q [$];
  vec_t        vecs [10];

  localparam logic [63:0] OrdL0   = 64'h0706_0504_0302_0100;
  localparam logic [63:0] OrdL1   = 64'h0F0E_0D0C_0B0A_0908;
  localparam logic [63:0] OrdL1W6 = 64'h0D0C_0B0A_0908_0F0E;
  localparam logic [63:0] OrdL1W3 = 64'h0A09_080F_0E0D_0C0B;
  localparam logic [63:0] OrdL7W7 = 64'h3E3D_3C3B_3A39_383F;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input bit rd, input logic [31:0] addr, input logic [63:0] wbase,
                              input bit inject, input bit b2b, input logic [63:0] order);
    vec_t v;
    v.rd     = rd;
    v.addr   = addr;
    v.wbase  = wbase;
    v.inject = inject;
    v.b2b    = b2b;
    v.order  = order;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full transfer starting now (cycle 0) and returns at cycle 21.
  task automatic run_xfer(input vec_t v, input int idx);
    logic [63:0] wd [8];
    logic [63:0] exp;
    logic [63:0] prev_do;
    logic        stb_start;
    logic        stb_prev;
    int          k_w = 0;
    int          edges = 0;
    int          edge_bad = 0;
    int          busy_bad = 0;
    int          oe_bad = 0;
    int          hold_bad = 0;
    for (int k = 0; k < 8; k++) wd[k] = v.wbase + 64'(k);
    if (v.rd) begin
      for (int k = 0; k < 8; k++) sb_q.push_back(shadow[v.order[8*k +: 8]]);
    end else begin
      for (int k = 0; k < 8; k++) shadow[v.order[8*k +: 8]] = wd[k];
    end
    bus.req      = 1'b1;
    bus.we_MEM   = v.rd;
    bus.addr_MEM = v.addr;
    bus.data_in  = wd[0];
    stb_start    = bus.stb;
    stb_prev     = bus.stb;
    prev_do      = bus.data_out;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk);
      #1;
      bus.req = v.inject && (c == 3 || c == 10);
      if (c == 1) begin
        bus.we_MEM   = ~v.rd;
        bus.addr_MEM = $urandom();
      end
      if (c <= 20 && bus.busy !== 1'b1) busy_bad++;
      if (c == 21 && bus.busy !== 1'b0) busy_bad++;
      if (bus.stb !== stb_prev) begin
        edges++;
        if (c < 6 || c > 20 || (c % 2) != 0) edge_bad++;
        if (v.rd) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL v%0d_sb: stb edge at cycle %0d with no expected beat", idx, c);
          end else begin
            exp = sb_q.pop_front();
            check($sformatf("v%0d_beat%0d", idx, edges - 1), bus.data_out, exp);
          end
          if (prev_do !== bus.data_out) hold_bad++;
        end else begin
          k_w++;
          if (k_w < 8) bus.data_in = wd[k_w];
        end
      end
      if (!v.rd && bus.data_oe !== 1'b0) oe_bad++;
      if (v.rd && c >= 5 && c <= 20 && bus.data_oe !== 1'b1) oe_bad++;
      if (c == 21 && bus.data_oe !== 1'b0) oe_bad++;
      stb_prev = bus.stb;
      prev_do  = bus.data_out;
    end
    check($sformatf("v%0d_busy_window", idx), 64'(busy_bad), 64'd0);
    check($sformatf("v%0d_stb_edges", idx), 64'(edges), 64'd8);
    check($sformatf("v%0d_stb_timing", idx), 64'(edge_bad), 64'd0);
    check($sformatf("v%0d_stb_level", idx), 64'(bus.stb), 64'(stb_start));
    check($sformatf("v%0d_data_oe", idx), 64'(oe_bad), 64'd0);
    if (v.rd) begin
      check($sformatf("v%0d_pre_edge_hold", idx), 64'(hold_bad), 64'd0);
      check($sformatf("v%0d_sb_drain", idx), 64'(sb_q.size()), 64'd0);
      check($sformatf("v%0d_idle_hold", idx), bus.data_out, shadow[v.order[63:56]]);
      sb_q.delete();
    end
  endtask

  // Starts a transfer, then pulls rst_n low mid-cycle at cycle 'at' and checks the abort.
  task automatic abort_xfer(input vec_t v, input int at, input string name);
    logic [63:0] wd [8];
    logic        stb_prev;
    int          k_w = 0;
    for (int k = 0; k < 8; k++) wd[k] = v.wbase + 64'(k);
    bus.req      = 1'b1;
    bus.we_MEM   = v.rd;
    bus.addr_MEM = v.addr;
    bus.data_in  = wd[0];
    stb_prev     = bus.stb;
    for (int c = 1; c <= at; c++) begin
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      if (bus.stb !== stb_prev) begin
        k_w++;
        if (k_w < 8) bus.data_in = wd[k_w];
      end
      stb_prev = bus.stb;
    end
    // Beat k is committed by the posedge that starts cycle 6+2k
    if (!v.rd) begin
      for (int k = 0; k < 8; k++) begin
        if (6 + 2 * k <= at) shadow[v.order[8*k +: 8]] = wd[k];
      end
    end
    check({name, "_busy_before"}, 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_stb"}, 64'(bus.stb), 64'd0);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    check({name, "_data_oe"}, 64'(bus.data_oe), 64'd0);
    check({name, "_data_out"}, bus.data_out, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req      = 1'b0;
    bus.we_MEM   = 1'b0;
    bus.addr_MEM = '0;
    bus.data_in  = '0;

    vecs[0] = mk(1'b0, 32'h0000_0040, 64'h1111_0000_0000_0008, 1'b0, 1'b1, OrdL1);
    vecs[1] = mk(1'b1, 32'h0000_0040, 64'h0,                   1'b0, 1'b0, OrdL1);
    vecs[2] = mk(1'b1, 32'h0000_0070, 64'h0,                   1'b0, 1'b0, OrdL1W6);
    vecs[3] = mk(1'b0, 32'h0000_0000, 64'h0000_0000_0000_00A0, 1'b0, 1'b0, OrdL0);
    vecs[4] = mk(1'b1, 32'h0000_0000, 64'h0,                   1'b0, 1'b0, OrdL0);
    vecs[5] = mk(1'b1, 32'hFFFF_F840, 64'h0,                   1'b0, 1'b0, OrdL1);
    vecs[6] = mk(1'b1, 32'h0000_0040, 64'h0,                   1'b1, 1'b0, OrdL1);
    vecs[7] = mk(1'b1, 32'h0000_0058, 64'h0,                   1'b0, 1'b1, OrdL1W3);
    vecs[8] = mk(1'b0, 32'h0000_01F8, 64'hC0DE_0000_0000_0000, 1'b1, 1'b0, OrdL7W7);
    vecs[9] = mk(1'b1, 32'h0000_01F8, 64'h0,                   1'b0, 1'b0, OrdL7W7);

    idle(2);
    check("reset_stb", 64'(bus.stb), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_data_oe", 64'(bus.data_oe), 64'd0);
    check("reset_data_out", bus.data_out, 64'd0);

    // Release mid-cycle so the first request is sampled on the very next posedge
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].b2b) idle(2);
      run_xfer(vecs[i], i);
    end

    // Write to line 0 aborted during beat 2's data cycle: entries 0-1 new, 2-7 keep A2..A7
    idle(2);
    abort_xfer(mk(1'b0, 32'h0000_0000, 64'h0000_0000_0000_5500, 1'b0, 1'b0, OrdL0), 9, "abort_wr");
    idle(1);
    run_xfer(mk(1'b1, 32'h0000_0000, 64'h0, 1'b0, 1'b0, OrdL0), 10);

    // Read aborted right after its first stb edge, then the line must read back intact
    idle(2);
    abort_xfer(mk(1'b1, 32'h0000_0040, 64'h0, 1'b0, 1'b0, OrdL1), 6, "abort_rd");
    run_xfer(mk(1'b1, 32'h0000_0040, 64'h0, 1'b0, 1'b0, OrdL1), 11);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_mem_burst.md
MAIN_MEM_BURST -- requirements
Module: main_mem_burst

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning request address width.
REQ-002 SHALL have parameter DATA_WIDTH_MEM, default 64, meaning memory bus width.
REQ-003 SHALL have parameter BURST_LENGTH, default 8, meaning beats per line transfer.
REQ-004 SHALL have parameter ACCESS_LATENCY, default 4, meaning cycles from request accept to first beat.
REQ-005 SHALL have parameter MEM_DEPTH, default 256, meaning number of 64-bit storage entries.
REQ-006 SHALL have port clk, input, 1, the only clock; all logic on posedge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req, input, 1, request strobe from L2, sampled on posedge.
REQ-009 SHALL have port we_MEM, input, 1, 1 = read line from memory, 0 = write line to memory.
REQ-010 SHALL have port addr_MEM, input, ADDR_WIDTH, byte address of the critical word.
REQ-011 SHALL have port data_in, input, DATA_WIDTH_MEM, write data from L2.
REQ-012 SHALL have port data_out, output, DATA_WIDTH_MEM, read data to L2.
REQ-013 SHALL have port data_oe, output, 1, 1 = block drives data_out onto the shared data_MEM bus.
REQ-014 SHALL have port stb, output, 1, beat strobe; every edge (rise or fall) marks one beat.
REQ-015 SHALL have port busy, output, 1, transfer in progress.

Function
REQ-016 SHALL implement states IDLE, LATENCY, BURST_DATA, BURST_STB.
REQ-017 In IDLE, req=1 at posedge (cycle 0) SHALL capture we_MEM and addr_MEM, go to LATENCY, and assert busy from cycle 1.
REQ-018 SHALL ignore req while busy=1; no queuing; later changes to addr_MEM/we_MEM SHALL have no effect.
REQ-019 LATENCY SHALL last exactly ACCESS_LATENCY cycles (cycles 1-4 by default).
REQ-020 Beat k (0..7) SHALL occupy BURST_DATA at cycle 5+2k and BURST_STB at cycle 6+2k.
REQ-021 Beat k SHALL address entry {addr[10:6], (addr[5:3]+k) mod 8}: critical word first, wrapping within the 64-byte line.
REQ-022 Address bits above 10 and bits 2:0 SHALL be ignored; higher addresses alias.
REQ-023 Read, BURST_DATA: data_out SHALL load the beat's entry and data_oe=1; in BURST_STB stb SHALL toggle while data_out is held.
REQ-024 Read: data_out SHALL stay stable from one cycle before each stb edge until the next BURST_DATA.
REQ-025 Write: data_oe SHALL stay 0; BURST_DATA SHALL write data_in to the beat's entry; BURST_STB SHALL toggle stb as acknowledge, after which L2 presents the next word.
REQ-026 After the BURST_STB of beat 7 (cycle 20) SHALL return to IDLE, with busy=0 and data_oe=0 from cycle 21.
REQ-027 A req at cycle 21 SHALL be accepted (back-to-back requests allowed).
REQ-028 stb SHALL toggle exactly BURST_LENGTH times per transfer, so its level after a transfer equals its level before.
REQ-029 data_out SHALL hold its last value in IDLE.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, stb=0, busy=0, data_oe=0, data_out=0 and clear captured address/beat counter.
REQ-031 Reset mid-transfer SHALL abort the transfer; entries already written SHALL persist; memory contents SHALL never be reset.
REQ-032 The first req SHALL be accepted on the first posedge after rst_n rises.

Structure
REQ-033 Package mem_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH_MEM, BURST_LENGTH, the line/word bit-field constants and the state enum, shared with the L2 cache.
REQ-034 Storage SHALL be a sub-module mem_array: single-port, synchronous write, MEM_DEPTH x 64.
REQ-035 Beat counter SHALL be 3 bits; latency counter SHALL be $clog2(ACCESS_LATENCY+1) bits.

Verification
REQ-036 Preload entry n = 64'h1111_0000_0000_0000+n; read req at addr 32'h0000_0040 -> beats 8..15 in order, busy for cycles 1-20, exactly 8 stb edges.
REQ-037 Read at addr 32'h0000_0070 -> entry order 14,15,8,9,10,11,12,13 (wrap).
REQ-038 Write at addr 32'h0000_0000 with data_in = 64'hA0+k on beat k -> entries 0..7 = A0..A7; data_oe never 1; a following read returns A0..A7.
REQ-039 req pulsed at cycles 3 and 10 during a transfer -> ignored, no extra stb edges; req at cycle 21 -> accepted.
REQ-040 rst_n low at cycle 9 of a write to 32'h0000_0000 -> outputs reset at once; entries 0-1 updated, entries 2-7 unchanged.
REQ-041 Read at addr 32'hFFFF_F840 -> same data as a read at 32'h0000_0040 (aliasing).
